vfilter_ctrl: RTL and testbench



---
 rtl/vfilter_ctrl_if.sv | 28 ++
 rtl/vfilter_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_vfilter_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vfilter_ctrl_if.sv
// Pixel-in / tap-out stream bundle for the vertical filter front end.
// The upstream raster source is the master; the row scheduler is the slave.
interface vfilter_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TAP_NUMS   = 3
);
    logic                           pix_valid;
    logic                           pix_ready;
    logic [DATA_WIDTH-1:0]          pix_data;
    logic                           tap_valid;
    logic [TAP_NUMS*DATA_WIDTH-1:0] tap_data;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  tap_valid,
        input  tap_data
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output tap_valid,
        output tap_data
    );
endinterface

// File: rtl/vfilter_ctrl.sv
// Row scheduler and line-buffer controller for the 3-tap vertical filter.
// Keeps the two previous rows in LB_A/LB_B and emits {below, center, above} taps.
//
// state   | meaning
// IDLE    | waiting for start_i, frame config latched on start
// FILL    | row 0 written into LB_A, no taps
// RUN     | input rows 1..H-1, one tap per accepted pixel
// FLUSH   | output row H-1 replayed from line buffers, input stalled
// LAST    | final flush tap on the output register
// DONE    | one-cycle done_o pulse
module vfilter_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int TAP_NUMS    = 3,
    parameter int COEFF_WIDTH = 14,
    parameter int IMG_W_MAX   = 1920,
    parameter int CNT_W       = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [CNT_W-1:0]              cfg_width_i,
    input  logic [CNT_W-1:0]              cfg_height_i,
    input  logic signed [COEFF_WIDTH-1:0] cfg_coeff00_i,
    input  logic signed [COEFF_WIDTH-1:0] cfg_coeff10_i,
    input  logic signed [COEFF_WIDTH-1:0] cfg_coeff20_i,
    vfilter_ctrl_if.slave                 pix_if,
    output logic signed [COEFF_WIDTH-1:0] coeff00_v_o,
    output logic signed [COEFF_WIDTH-1:0] coeff10_v_o,
    output logic signed [COEFF_WIDTH-1:0] coeff20_v_o,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_LAST,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] height_q, height_d;

    logic signed [COEFF_WIDTH-1:0] c00_q, c00_d;
    logic signed [COEFF_WIDTH-1:0] c10_q, c10_d;
    logic signed [COEFF_WIDTH-1:0] c20_q, c20_d;

    logic                           tap_valid_q, tap_valid_d;
    logic [TAP_NUMS*DATA_WIDTH-1:0] tap_data_q, tap_data_d;

    // Line buffers are deliberately not reset: every location read in a
    // frame has been written earlier in that same frame.
    logic [DATA_WIDTH-1:0] lb_a [IMG_W_MAX];
    logic [DATA_WIDTH-1:0] lb_b [IMG_W_MAX];

    logic [DATA_WIDTH-1:0] lb_a_rd;
    logic [DATA_WIDTH-1:0] lb_b_rd;
    logic                  lb_a_we;
    logic                  lb_b_we;

    logic pix_ready_s;
    logic accept;
    logic col_last;
    logic row_last;
    logic single_row;

    assign pix_ready_s = (state_q == S_FILL) || (state_q == S_RUN);
    assign accept      = pix_if.pix_valid & pix_ready_s;
    assign col_last    = (col_q == width_q - CNT_W'(1));
    assign row_last    = (row_q == height_q - CNT_W'(1));
    assign single_row  = (height_q == CNT_W'(1));

    assign lb_a_rd = lb_a[col_q];
    assign lb_b_rd = lb_b[col_q];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        width_d     = width_q;
        height_d    = height_q;
        c00_d       = c00_q;
        c10_d       = c10_q;
        c20_d       = c20_q;
        tap_valid_d = 1'b0;
        tap_data_d  = tap_data_q;
        lb_a_we     = 1'b0;
        lb_b_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    width_d  = cfg_width_i;
                    height_d = cfg_height_i;
                    c00_d    = cfg_coeff00_i;
                    c10_d    = cfg_coeff10_i;
                    c20_d    = cfg_coeff20_i;
                    col_d    = '0;
                    row_d    = '0;
                    if ((cfg_width_i == '0) || (cfg_height_i == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (accept) begin
                    lb_a_we = 1'b1;
                    if (col_last) begin
                        col_d   = '0;
                        row_d   = CNT_W'(1);
                        state_d = single_row ? S_FLUSH : S_RUN;
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (accept) begin
                    lb_a_we     = 1'b1;
                    lb_b_we     = 1'b1;
                    tap_valid_d = 1'b1;
                    // On input row 1 LB_B holds nothing yet; replicate row 0 upward.
                    tap_data_d  = {pix_if.pix_data, lb_a_rd,
                                   (row_q == CNT_W'(1)) ? lb_a_rd : lb_b_rd};
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            state_d = S_FLUSH;
                        end else begin
                            row_d = row_q + CNT_W'(1);
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end

            S_FLUSH: begin
                tap_valid_d = 1'b1;
                tap_data_d  = {lb_a_rd, lb_a_rd, single_row ? lb_a_rd : lb_b_rd};
                if (col_last) begin
                    col_d   = '0;
                    state_d = S_LAST;
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end

            // Holds off done_o until the last flush tap has left the output register.
            S_LAST: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            c00_q       <= '0;
            c10_q       <= '0;
            c20_q       <= '0;
            tap_valid_q <= 1'b0;
            tap_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            width_q     <= width_d;
            height_q    <= height_d;
            c00_q       <= c00_d;
            c10_q       <= c10_d;
            c20_q       <= c20_d;
            tap_valid_q <= tap_valid_d;
            tap_data_q  <= tap_data_d;
        end
    end

    // Read-before-write: LB_B takes the old LB_A value of the same column.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (lb_a_we) begin
                lb_a[col_q] <= pix_if.pix_data;
            end
            if (lb_b_we) begin
                lb_b[col_q] <= lb_a_rd;
            end
        end
    end

    assign pix_if.pix_ready = pix_ready_s;
    assign pix_if.tap_valid = tap_valid_q;
    assign pix_if.tap_data  = tap_data_q;

    assign coeff00_v_o = c00_q;
    assign coeff10_v_o = c10_q;
    assign coeff20_v_o = c20_q;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_vfilter_ctrl.sv
// Self-checking bench for vfilter_ctrl: random frames against a row-replication
// model of the expected tap triples, plus timing checks on latency and done_o.
module tb_vfilter_ctrl;

    localparam int DW    = 8;
    localparam int CW    = 14;
    localparam int CNT_W = 11;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic [CNT_W-1:0] cfg_width_i, cfg_height_i;
    logic [CW-1:0] cfg_coeff00_i, cfg_coeff10_i, cfg_coeff20_i;
    logic [CW-1:0] coeff00_v_o, coeff10_v_o, coeff20_v_o;
    logic busy_o, done_o;

    vfilter_ctrl_if #(.DATA_WIDTH(DW), .TAP_NUMS(3)) pix_if ();

    vfilter_ctrl #(
        .DATA_WIDTH(DW), .TAP_NUMS(3), .COEFF_WIDTH(CW), .IMG_W_MAX(1920), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
        .cfg_coeff00_i(cfg_coeff00_i), .cfg_coeff10_i(cfg_coeff10_i), .cfg_coeff20_i(cfg_coeff20_i),
        .pix_if(pix_if),
        .coeff00_v_o(coeff00_v_o), .coeff10_v_o(coeff10_v_o), .coeff20_v_o(coeff20_v_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, filled at the falling edge away from the active edge.
    logic [23:0] tap_q[$];
    int tap_cyc[$];
    int acc_cyc[$];
    int done_cnt;
    int done_cyc;
    int coeff_bad;
    bit chk_coeff = 1'b0;
    logic [CW-1:0] exp_c0, exp_c1, exp_c2;

    always @(negedge clk) begin
        if (pix_if.pix_valid && pix_if.pix_ready) acc_cyc.push_back(cyc);
        if (pix_if.tap_valid) begin
            tap_q.push_back(pix_if.tap_data);
            tap_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (chk_coeff && busy_o &&
            ({coeff00_v_o, coeff10_v_o, coeff20_v_o} !== {exp_c0, exp_c1, exp_c2}))
            coeff_bad = coeff_bad + 1;
    end

    logic [DW-1:0] img [0:7][0:15];

    // Output row r uses rows r-1, r, r+1 with top/bottom rows replicated.
    function automatic logic [23:0] exp_tap(input int r, input int x, input int h);
        int ra, rb;
        ra = (r > 0) ? r - 1 : 0;
        rb = (r < h - 1) ? r + 1 : h - 1;
        return {img[rb][x], img[r][x], img[ra][x]};
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = DW'(16 * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = DW'($urandom_range(255));
    endtask

    task automatic set_coeffs(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] c);
        cfg_coeff00_i = a; cfg_coeff10_i = b; cfg_coeff20_i = c;
        exp_c0 = a; exp_c1 = b; exp_c2 = c;
    endtask

    // Start one frame and stream its pixels; abort_at >= 0 stops feeding at that pixel index.
    task automatic run_frame(input int w, input int h, input int gap_pct, input int abort_at,
                             input bit poke_start, output logic busy_s, output logic ready_s);
        int idx;
        int guard;
        bit v;
        bit acc;
        tap_q.delete(); tap_cyc.delete(); acc_cyc.delete();
        done_cnt = 0; done_cyc = -1; coeff_bad = 0;
        cfg_width_i = CNT_W'(w); cfg_height_i = CNT_W'(h);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        busy_s = busy_o; ready_s = pix_if.pix_ready;
        idx = 0; guard = 0;
        while (idx < w * h && guard < 4000 && idx != abort_at) begin
            v = ($urandom_range(99) >= gap_pct);
            pix_if.pix_valid = v;
            pix_if.pix_data  = img[idx / w][idx % w];
            if (poke_start && idx == (w * h) / 2) begin
                start_i = 1'b1; cfg_width_i = CNT_W'(3); cfg_height_i = CNT_W'(2);
                cfg_coeff00_i = CW'($urandom_range(16383));
                cfg_coeff10_i = CW'($urandom_range(16383));
                cfg_coeff20_i = CW'($urandom_range(16383));
            end
            acc = v && pix_if.pix_ready;
            @(posedge clk); #1;
            start_i = 1'b0;
            if (acc) idx++;
            guard++;
        end
        if (abort_at < 0) begin
            // Keep valid high with junk while stalled: it must not be consumed.
            pix_if.pix_valid = 1'b1;
            pix_if.pix_data  = 8'hEE;
            for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
            repeat (3) @(posedge clk);
            #1;
            pix_if.pix_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1;
            start_i = 1'($urandom_range(1));
            cfg_width_i = CNT_W'($urandom_range(2047));
            cfg_height_i = CNT_W'($urandom_range(2047));
            cfg_coeff00_i = CW'($urandom_range(16383));
            cfg_coeff10_i = CW'($urandom_range(16383));
            cfg_coeff20_i = CW'($urandom_range(16383));
            pix_if.pix_valid = 1'($urandom_range(1));
            pix_if.pix_data = DW'($urandom_range(255));
            @(posedge clk); #1;
            n_vec++;
            if ({pix_if.pix_ready, pix_if.tap_valid, pix_if.tap_data, coeff00_v_o, coeff10_v_o,
                 coeff20_v_o, busy_o, done_o} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: ready=%b tap_valid=%b tap=%h c=%h/%h/%h busy=%b done=%b, required all 0",
                         pix_if.pix_ready, pix_if.tap_valid, pix_if.tap_data, coeff00_v_o,
                         coeff10_v_o, coeff20_v_o, busy_o, done_o);
            end
        end
        rst = 1'b0; start_i = 1'b0; pix_if.pix_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_continuous();
        logic b, r;
        fill_ramp();
        set_coeffs('0, '0, '0);
        run_frame(4, 3, 0, -1, 1'b0, b, r);
        n_vec++;
        if ({b, r} !== 2'b11) begin
            n_err++; $display("FAIL start_rise: busy=%b ready=%b required 1 1", b, r);
        end
        n_vec++;
        if (tap_q.size() !== 12) begin
            n_err++; $display("FAIL cont_tap_count: got %0d required 12", tap_q.size());
        end
        for (int k = 0; k < tap_q.size() && k < 12; k++) begin
            n_vec++;
            if (tap_q[k] !== exp_tap(k / 4, k % 4, 3)) begin
                n_err++; $display("FAIL cont_tap[%0d]: got %h required %h", k, tap_q[k], exp_tap(k / 4, k % 4, 3));
            end
        end
        if (tap_q.size() == 12 && acc_cyc.size() == 12) begin
            n_vec++;
            if (tap_q[0] !== 24'h100000) begin
                n_err++; $display("FAIL cont_first_tap: got %h required 100000", tap_q[0]);
            end
            n_vec++;
            if (tap_q[6] !== 24'h221202) begin
                n_err++; $display("FAIL cont_row1_x2: got %h required 221202", tap_q[6]);
            end
            n_vec++;
            if (tap_cyc[0] !== acc_cyc[4] + 1) begin
                n_err++; $display("FAIL cont_first_lag: tap at %0d required %0d", tap_cyc[0], acc_cyc[4] + 1);
            end
            for (int k = 9; k < 12; k++) begin
                n_vec++;
                if (tap_cyc[k] !== tap_cyc[8] + (k - 8)) begin
                    n_err++; $display("FAIL cont_flush_gap[%0d]: at %0d required %0d", k, tap_cyc[k], tap_cyc[8] + k - 8);
                end
            end
            n_vec++;
            if (done_cnt !== 1 || done_cyc !== tap_cyc[11] + 1) begin
                n_err++; $display("FAIL cont_done: count=%0d at %0d required 1 at %0d", done_cnt, done_cyc, tap_cyc[11] + 1);
            end
        end
    endtask

    task automatic test_single_row();
        logic b, r;
        img[0][0] = 8'hA5; img[0][1] = 8'h3C;
        run_frame(2, 1, 0, -1, 1'b0, b, r);
        n_vec++;
        if (tap_q.size() !== 2) begin
            n_err++; $display("FAIL row1_tap_count: got %0d required 2", tap_q.size());
        end
        if (tap_q.size() == 2 && acc_cyc.size() == 2) begin
            n_vec++;
            if (tap_q[0] !== 24'hA5A5A5 || tap_q[1] !== 24'h3C3C3C) begin
                n_err++; $display("FAIL row1_taps: got %h %h required a5a5a5 3c3c3c", tap_q[0], tap_q[1]);
            end
            n_vec++;
            if (tap_cyc[0] !== acc_cyc[1] + 2 || tap_cyc[1] !== tap_cyc[0] + 1) begin
                n_err++; $display("FAIL row1_flush_timing: taps at %0d %0d required %0d %0d",
                                  tap_cyc[0], tap_cyc[1], acc_cyc[1] + 2, acc_cyc[1] + 3);
            end
            n_vec++;
            if (done_cnt !== 1 || done_cyc !== tap_cyc[1] + 1) begin
                n_err++; $display("FAIL row1_done: count=%0d at %0d required 1 at %0d", done_cnt, done_cyc, tap_cyc[1] + 1);
            end
        end
    endtask

    task automatic test_zero_size();
        logic b, r;
        run_frame(0, 3, 0, -1, 1'b0, b, r);
        n_vec++;
        if (tap_q.size() !== 0 || done_cnt !== 1) begin
            n_err++; $display("FAIL zero_size: taps=%0d done=%0d required 0 taps 1 done", tap_q.size(), done_cnt);
        end
    endtask

    // Shared by the gap, random and coefficient scenarios: run then check every tap and timing.
    task automatic test_frame_full(input string nm, input int w, input int h, input int gap, input bit poke);
        logic b, r;
        int nr;
        run_frame(w, h, gap, -1, poke, b, r);
        nr = w * (h - 1);
        n_vec++;
        if (tap_q.size() !== w * h || acc_cyc.size() !== w * h) begin
            n_err++; $display("FAIL %s_count: taps=%0d pixels=%0d required %0d", nm, tap_q.size(), acc_cyc.size(), w * h);
        end
        for (int k = 0; k < tap_q.size() && k < w * h; k++) begin
            n_vec++;
            if (tap_q[k] !== exp_tap(k / w, k % w, h)) begin
                n_err++; $display("FAIL %s_tap[%0d]: got %h required %h", nm, k, tap_q[k], exp_tap(k / w, k % w, h));
            end
        end
        if (tap_q.size() == w * h && acc_cyc.size() == w * h) begin
            for (int k = 0; k < w * h; k++) begin
                n_vec++;
                if (k < nr && tap_cyc[k] !== acc_cyc[w + k] + 1) begin
                    n_err++; $display("FAIL %s_lag[%0d]: at %0d required %0d", nm, k, tap_cyc[k], acc_cyc[w + k] + 1);
                end else if (k == nr && tap_cyc[k] !== acc_cyc[w * h - 1] + 2) begin
                    n_err++; $display("FAIL %s_flush_start: at %0d required %0d", nm, tap_cyc[k], acc_cyc[w * h - 1] + 2);
                end else if (k > nr && tap_cyc[k] !== tap_cyc[k - 1] + 1) begin
                    n_err++; $display("FAIL %s_flush_gap[%0d]: at %0d required %0d", nm, k, tap_cyc[k], tap_cyc[k - 1] + 1);
                end
            end
            n_vec++;
            if (done_cnt !== 1 || done_cyc !== tap_cyc[w * h - 1] + 1) begin
                n_err++; $display("FAIL %s_done: count=%0d at %0d required 1 at %0d", nm, done_cnt, done_cyc, tap_cyc[w * h - 1] + 1);
            end
        end
        n_vec++;
        if (coeff_bad !== 0) begin
            n_err++; $display("FAIL %s_coeff_hold: %0d bad cycles required 0", nm, coeff_bad);
        end
    endtask

    task automatic test_gaps();
        fill_random();
        chk_coeff = 1'b1;
        test_frame_full("gaps", 5, 4, 40, 1'b0);
        chk_coeff = 1'b0;
    endtask

    task automatic test_coeff_isolation();
        fill_random();
        set_coeffs(14'h0800, 14'h1000, 14'h0800);
        chk_coeff = 1'b1;
        test_frame_full("coeff", 4, 3, 20, 1'b1);
        chk_coeff = 1'b0;
        n_vec++;
        if ({coeff00_v_o, coeff10_v_o, coeff20_v_o} !== {14'h0800, 14'h1000, 14'h0800}) begin
            n_err++; $display("FAIL coeff_after: got %h/%h/%h required 0800/1000/0800", coeff00_v_o, coeff10_v_o, coeff20_v_o);
        end
    endtask

    task automatic test_reset_mid_run();
        logic b, r;
        fill_ramp();
        set_coeffs(14'h0123, 14'h0456, 14'h0789);
        run_frame(4, 3, 0, 10, 1'b0, b, r);
        rst = 1'b1; pix_if.pix_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({pix_if.pix_ready, pix_if.tap_valid, pix_if.tap_data, coeff00_v_o, coeff10_v_o,
             coeff20_v_o, busy_o, done_o} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: ready=%b tap_valid=%b tap=%h c=%h/%h/%h busy=%b done=%b, required all 0",
                     pix_if.pix_ready, pix_if.tap_valid, pix_if.tap_data, coeff00_v_o, coeff10_v_o,
                     coeff20_v_o, busy_o, done_o);
        end
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt !== 0) begin
            n_err++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt);
        end
        set_coeffs('0, '0, '0);
        test_frame_full("fresh", 4, 3, 0, 1'b0);
    endtask

    task automatic test_random_frames();
        int w, h, g;
        for (int f = 0; f < 6; f++) begin
            fill_random();
            w = $urandom_range(16, 1);
            h = $urandom_range(8, 1);
            g = $urandom_range(60, 0);
            set_coeffs(CW'($urandom_range(16383)), CW'($urandom_range(16383)), CW'($urandom_range(16383)));
            chk_coeff = 1'b1;
            test_frame_full("rand", w, h, g, 1'b0);
            chk_coeff = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0;
        cfg_width_i = '0; cfg_height_i = '0;
        cfg_coeff00_i = '0; cfg_coeff10_i = '0; cfg_coeff20_i = '0;
        pix_if.pix_valid = 1'b0; pix_if.pix_data = '0;
        exp_c0 = '0; exp_c1 = '0; exp_c2 = '0;
        done_cnt = 0; done_cyc = -1; coeff_bad = 0;
        test_reset();
        test_continuous();
        test_single_row();
        test_zero_size();
        test_gaps();
        test_coeff_isolation();
        test_reset_mid_run();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
